// File: rtl/axi_mover_scheduler.sv
// Round-robin scheduler sharing one axi_data_mover between NumReq requesters.
// Latency: accept at T, mover_valid_o from T+1, done pulse one cycle after the mover returns to idle.
// Backpressure: holds the command on mover_valid_o until mover_ready_i; req_ready_o stays low while not Idle.
// Optional feature macro: AXI_MOVER_SCHED_ZERO_LEN_SKIP_EN (zero-length commands complete without touching the mover).
module axi_mover_scheduler #(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    localparam int GrantW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumReq-1:0]                   req_valid_i,
    output logic [NumReq-1:0]                   req_ready_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_src_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_dst_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]    req_len_i,
    output logic [NumReq-1:0]                   done_o,
    input  logic                                mover_ready_i,
    output logic                                mover_valid_o,
    output logic [AddrWidth-1:0]                mover_src_o,
    output logic [AddrWidth-1:0]                mover_dst_o,
    output logic [AddrWidth-1:0]                mover_len_o,
    output logic                                busy_o,
    output logic [GrantW-1:0]                   grant_o
);

    // Lengths are truncated to whole mover beats.
    localparam int BeatBits = (DataWidth / 8 > 1) ? $clog2(DataWidth / 8) : 0;
    localparam logic [AddrWidth-1:0] LenMask =
        ~((AddrWidth'(1) << BeatBits) - AddrWidth'(1));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [GrantW-1:0]      rr_q, rr_d;
    logic [GrantW-1:0]      grant_q, grant_d;
    logic [AddrWidth-1:0]   src_q, src_d;
    logic [AddrWidth-1:0]   dst_q, dst_d;
    logic [AddrWidth-1:0]   len_q, len_d;
    logic                   busy_first_q, busy_first_d;

    logic                   win_vld;
    logic [GrantW-1:0]      win_idx;
    logic [AddrWidth-1:0]   win_len;

    // (base + off) mod NumReq, with both operands already below NumReq.
    function automatic logic [GrantW-1:0] wrap_add(input logic [GrantW-1:0] base,
                                                   input int unsigned off);
        logic [GrantW:0] sum;
        sum = {1'b0, base} + (GrantW + 1)'(off);
        if (sum >= (GrantW + 1)'(NumReq)) begin
            sum = sum - (GrantW + 1)'(NumReq);
        end
        return sum[GrantW-1:0];
    endfunction

    // Rotating-priority search starting at rr_q; first valid requester wins.
    always_comb begin
        logic [GrantW-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = wrap_add(rr_q, k);
            if (!win_vld && req_valid_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
        win_len = req_len_i[win_idx] & LenMask;
    end

    // Next-state, command capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        req_ready_o  = '0;
        done_o       = '0;
        // Mover ready drops for a cycle after accept, so the first Busy cycle is never a completion.
        busy_first_d = (state_q == ST_ISSUE);
        case (state_q)
            ST_IDLE: begin
                if (win_vld && !rst_i) begin
                    req_ready_o[win_idx] = 1'b1;
                    src_d   = req_src_i[win_idx];
                    dst_d   = req_dst_i[win_idx];
                    len_d   = win_len;
                    grant_d = win_idx;
                    rr_d    = wrap_add(win_idx, 1);
`ifdef AXI_MOVER_SCHED_ZERO_LEN_SKIP_EN
                    state_d = (win_len == '0) ? ST_DONE : ST_ISSUE;
`else
                    state_d = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                if (mover_ready_i) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!busy_first_q && mover_ready_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o[grant_q] = 1'b1;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and command registers; reset also aborts any command in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            busy_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            busy_first_q <= busy_first_d;
        end
    end

    assign mover_valid_o = (state_q == ST_ISSUE);
    assign mover_src_o   = src_q;
    assign mover_dst_o   = dst_q;
    assign mover_len_o   = len_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign grant_o       = (state_q == ST_IDLE) ? win_idx : grant_q;

endmodule

// File: tb/tb_axi_mover_scheduler.sv
module tb_axi_mover_scheduler;

    localparam int NR = 4;
    localparam int AW = 64;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0][AW-1:0]  req_src;
    logic [NR-1:0][AW-1:0]  req_dst;
    logic [NR-1:0][AW-1:0]  req_len;
    logic [NR-1:0]          done;
    logic                   mover_ready;
    logic                   mover_valid;
    logic [AW-1:0]          mover_src;
    logic [AW-1:0]          mover_dst;
    logic [AW-1:0]          mover_len;
    logic                   busy;
    logic [1:0]             grant;

    int errors = 0;
    int checks = 0;

    axi_mover_scheduler #(
        .NumReq   (NR),
        .AddrWidth(AW),
        .DataWidth(64)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_src_i    (req_src),
        .req_dst_i    (req_dst),
        .req_len_i    (req_len),
        .done_o       (done),
        .mover_ready_i(mover_ready),
        .mover_valid_o(mover_valid),
        .mover_src_o  (mover_src),
        .mover_dst_o  (mover_dst),
        .mover_len_o  (mover_len),
        .busy_o       (busy),
        .grant_o      (grant)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid   = '0;
        req_src     = '0;
        req_dst     = '0;
        req_len     = '0;
        mover_ready = 1'b1;
        rst         = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Starts in Issue with the mover ready: mover accepts, stays busy n cycles,
    // returns to idle; then waits (bounded) for the done pulse.
    task automatic finish_xfer(input int n, output logic [NR-1:0] d, output int lat);
        mover_ready = 1'b1;
        tick();
        mover_ready = 1'b0;
        repeat (n) tick();
        mover_ready = 1'b1;
        d   = '0;
        lat = -1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done !== '0) begin
                d   = done;
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mover_valid !== 1'b0) begin errors++; $display("FAIL reset_mvalid: got %b want 0", mover_valid); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b want 0000", done); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d want 0", grant); end
        checks++; if (mover_len !== 64'h0) begin errors++; $display("FAIL reset_mlen: got %h want 0", mover_len); end
    endtask

    task automatic test_single();
        logic [NR-1:0] d;
        int lat;
        do_reset();
        req_src[0]   = 64'h1000;
        req_dst[0]   = 64'h8000;
        req_len[0]   = 64'h800;
        req_valid    = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (mover_valid !== 1'b1) begin errors++; $display("FAIL single_mvalid: got %b want 1", mover_valid); end
        checks++; if (mover_src !== 64'h1000) begin errors++; $display("FAIL single_src: got %h want 1000", mover_src); end
        checks++; if (mover_dst !== 64'h8000) begin errors++; $display("FAIL single_dst: got %h want 8000", mover_dst); end
        checks++; if (mover_len !== 64'h800) begin errors++; $display("FAIL single_len: got %h want 800", mover_len); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        finish_xfer(31, d, lat);
        checks++; if (d !== 4'b0001) begin errors++; $display("FAIL single_done: got %b want 0001", d); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL single_done_lat: got %0d want 0", lat); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_once: got %b want 0000", done); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] d;
        logic [NR-1:0] exp;
        int lat;
        int g;
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_src[i] = 64'h10000 + 64'(i) * 64'h100;
            req_dst[i] = 64'h20000 + 64'(i) * 64'h100;
            req_len[i] = 64'h40;
        end
        req_valid = 4'b1111;
        #1;
        for (int it = 0; it < 5; it++) begin
            g   = it % NR;
            exp = 4'b0001 << g;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_ready_%0d: got %b want %b", it, req_ready, exp); end
            checks++; if (grant !== 2'(g)) begin errors++; $display("FAIL rr_grant_%0d: got %0d want %0d", it, grant, g); end
            tick();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_noready_%0d: got %b want 0000", it, req_ready); end
            checks++; if (mover_src !== 64'h10000 + 64'(g) * 64'h100) begin errors++; $display("FAIL rr_src_%0d: got %h", it, mover_src); end
            finish_xfer(2, d, lat);
            checks++; if (d !== exp) begin errors++; $display("FAIL rr_done_%0d: got %b want %b", it, d, exp); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_len_mask();
        logic [NR-1:0] d;
        int lat;
        do_reset();
        req_len[1] = 64'h107;
        req_valid  = 4'b0010;
        tick();
        req_valid = '0;
        checks++; if (mover_len !== 64'h100) begin errors++; $display("FAIL lenmask: got %h want 100", mover_len); end
        finish_xfer(2, d, lat);
        checks++; if (d !== 4'b0010) begin errors++; $display("FAIL lenmask_done: got %b want 0010", d); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [NR-1:0] d;
        int lat;
        do_reset();
        mover_ready = 1'b0;
        req_src[3]  = 64'hA000;
        req_dst[3]  = 64'hB000;
        req_len[3]  = 64'h80;
        req_valid   = 4'b1000;
        tick();
        req_src[3] = 64'hDEAD;
        req_src[0] = 64'h3000;
        req_valid  = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            checks++; if (mover_valid !== 1'b1) begin errors++; $display("FAIL bp_mvalid_%0d: got %b want 1", c, mover_valid); end
            checks++; if (mover_src !== 64'hA000) begin errors++; $display("FAIL bp_src_%0d: got %h want a000", c, mover_src); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_%0d: got %b want 0000", c, req_ready); end
            tick();
        end
        req_valid = '0;
        finish_xfer(2, d, lat);
        checks++; if (d !== 4'b1000) begin errors++; $display("FAIL bp_done: got %b want 1000", d); end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        logic [NR-1:0] d;
        logic [NR-1:0] seen;
        int lat;
        do_reset();
        req_src[0] = 64'h4000;
        req_len[0] = 64'h100;
        req_valid  = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        mover_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        mover_ready = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmb_busy: got %b want 0", busy); end
        checks++; if (mover_valid !== 1'b0) begin errors++; $display("FAIL rmb_mvalid: got %b want 0", mover_valid); end
        checks++; if (done !== 4'b0000) begin errors++; $display("FAIL rmb_done: got %b want 0000", done); end
        checks++; if (grant !== 2'd0) begin errors++; $display("FAIL rmb_grant: got %0d want 0", grant); end
        checks++; if (mover_src !== 64'h0) begin errors++; $display("FAIL rmb_src: got %h want 0", mover_src); end
        seen = '0;
        repeat (5) begin
            tick();
            seen = seen | done;
        end
        checks++; if (seen !== 4'b0000) begin errors++; $display("FAIL rmb_no_done: got %b want 0000", seen); end
        req_src[2] = 64'h5000;
        req_len[2] = 64'h40;
        req_valid  = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmb_ready2: got %b want 0100", req_ready); end
        checks++; if (grant !== 2'd2) begin errors++; $display("FAIL rmb_grant2: got %0d want 2", grant); end
        tick();
        req_valid = '0;
        checks++; if (mover_src !== 64'h5000) begin errors++; $display("FAIL rmb_src2: got %h want 5000", mover_src); end
        finish_xfer(2, d, lat);
        checks++; if (d !== 4'b0100) begin errors++; $display("FAIL rmb_done2: got %b want 0100", d); end
        tick();
    endtask

    task automatic test_zero_len();
        logic [NR-1:0] d;
        int lat;
        do_reset();
        req_src[1] = 64'h6000;
        req_len[1] = 64'h5;
        req_valid  = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zl_ready: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
`ifdef AXI_MOVER_SCHED_ZERO_LEN_SKIP_EN
        checks++; if (done !== 4'b0010) begin errors++; $display("FAIL zl_done: got %b want 0010", done); end
        checks++; if (mover_valid !== 1'b0) begin errors++; $display("FAIL zl_mvalid: got %b want 0", mover_valid); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zl_idle: got %b want 0", busy); end
        checks++; if (mover_valid !== 1'b0) begin errors++; $display("FAIL zl_mvalid2: got %b want 0", mover_valid); end
`else
        checks++; if (mover_valid !== 1'b1) begin errors++; $display("FAIL zl_mvalid: got %b want 1", mover_valid); end
        checks++; if (mover_len !== 64'h0) begin errors++; $display("FAIL zl_len: got %h want 0", mover_len); end
        finish_xfer(2, d, lat);
        checks++; if (d !== 4'b0010) begin errors++; $display("FAIL zl_done: got %b want 0010", d); end
        tick();
`endif
    endtask

    initial begin
        req_valid   = '0;
        req_src     = '0;
        req_dst     = '0;
        req_len     = '0;
        mover_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_len_mask();
        test_backpressure();
        test_reset_mid_busy();
        test_zero_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
